// File: rtl/steel_fetch_unit.sv
// steel_fetch_unit: pipelined instruction fetch with request/grant/response memory port,
// DEPTH-entry {PC, instruction} prefetch queue and redirect/discard handling.
module steel_fetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter int                DEPTH        = 4,
    parameter logic [ADDR_W-1:0] BOOT_ADDRESS = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    output logic              o_i_req,
    output logic [ADDR_W-1:0] o_i_addr,
    input  logic              i_i_gnt,
    input  logic              i_i_rvalid,
    input  logic [31:0]       i_i_rdata,
    output logic              o_out_valid,
    output logic [31:0]       o_out_instr,
    output logic [ADDR_W-1:0] o_out_pc,
    input  logic              i_out_ready,
    output logic              o_fetch_fault
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_fpc, r_rpc;
    logic [CW-1:0]     r_count, r_outst, r_discard;
    logic              r_fault;
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [ADDR_W-1:0] r_pc_mem [DEPTH];
    logic [31:0]       r_ins_mem [DEPTH];

    logic [CW:0] w_used;
    logic        w_grant, w_rsp, w_push, w_pop;

    // Credit covers queued plus in-flight entries so a response can always be pushed.
    assign w_used        = {1'b0, r_count} + {1'b0, r_outst};
    assign o_i_req       = !i_reset && !i_redirect && !r_fault && (w_used < (CW+1)'(DEPTH));
    assign o_i_addr      = r_fpc;
    assign w_grant       = o_i_req && i_i_gnt;
    assign w_rsp         = i_i_rvalid && (r_outst != '0);
    assign w_push        = w_rsp && (r_discard == '0) && !i_redirect && !i_reset;
    assign o_out_valid   = r_count != '0;
    assign w_pop         = o_out_valid && i_out_ready && !i_redirect;
    assign o_out_pc      = o_out_valid ? r_pc_mem[r_rptr] : '0;
    assign o_out_instr   = o_out_valid ? r_ins_mem[r_rptr] : '0;
    assign o_fetch_fault = r_fault;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fpc     <= BOOT_ADDRESS;
            r_rpc     <= BOOT_ADDRESS;
            r_count   <= '0;
            r_outst   <= '0;
            r_discard <= '0;
            r_fault   <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
        end else if (i_redirect) begin
            r_fpc     <= i_redirect_addr;
            r_rpc     <= i_redirect_addr;
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_outst   <= r_outst - CW'(w_rsp);
            r_discard <= r_outst - CW'(w_rsp);
            r_fault   <= |i_redirect_addr[1:0];
        end else begin
            if (w_grant)
                r_fpc <= r_fpc + ADDR_W'(4);
            if (w_rsp && r_discard != '0)
                r_discard <= r_discard - CW'(1);
            if (w_push) begin
                r_rpc  <= r_rpc + ADDR_W'(4);
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            r_outst <= r_outst + CW'(w_grant) - CW'(w_rsp);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]  <= r_rpc;
            r_ins_mem[r_wptr] <= i_i_rdata;
        end
    end
endmodule

// File: tb/tb_steel_fetch_unit.sv
// tb_steel_fetch_unit: randomized bench comparing the fetch unit against a queue-based model
// driven by an in-order memory model with configurable latency.
module tb_steel_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, redir, gnt, rvalid, rdy;
    logic [31:0] raddr, rdata;
    logic        req, oval, fault;
    logic [31:0] addr, opc, oins;

    steel_fetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .BOOT_ADDRESS(32'h0)) dut (
        .i_clk(clk), .i_reset(rst), .i_redirect(redir), .i_redirect_addr(raddr),
        .o_i_req(req), .o_i_addr(addr), .i_i_gnt(gnt), .i_i_rvalid(rvalid),
        .i_i_rdata(rdata), .o_out_valid(oval), .o_out_instr(oins), .o_out_pc(opc),
        .i_out_ready(rdy), .o_fetch_fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
    typedef struct {logic [31:0] a; int due;} pend_t;

    ent_t        q[$];
    pend_t       mp[$];
    logic [31:0] m_fpc, m_rpc;
    int          m_outst, m_discard;
    bit          m_fault;
    int          cyc, last_due;
    int          p_gnt, p_ready, lat_min, lat_max;
    int          n_chk, n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h5A5A_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mp.delete();
        m_fpc = 32'h0;
        m_rpc = 32'h0;
        m_outst = 0;
        m_discard = 0;
        m_fault = 1'b0;
        last_due = cyc;
    endtask

    task automatic step(input bit s_rst, input bit s_redir, input logic [31:0] s_ra);
        bit          g, r, rv, exp_req;
        logic [31:0] hpc, hins;
        pend_t       p;
        ent_t        e;
        @(negedge clk);
        g  = $urandom_range(99) < p_gnt;
        r  = $urandom_range(99) < p_ready;
        rv = mp.size() > 0 && mp[0].due <= cyc;
        rst = s_rst; redir = s_redir; raddr = s_ra; gnt = g; rdy = r; rvalid = rv;
        rdata = rv ? mem_word(mp[0].a) : $urandom;
        #1;
        exp_req = !s_rst && !s_redir && !m_fault && (q.size() + m_outst < DEPTH);
        hpc = 32'h0; hins = 32'h0;
        if (q.size() > 0) begin hpc = q[0].pc; hins = q[0].ins; end
        chk("i_req", {31'h0, req}, {31'h0, exp_req});
        chk("i_addr", addr, m_fpc);
        chk("out_valid", {31'h0, oval}, {31'h0, q.size() > 0});
        chk("out_pc", opc, hpc);
        chk("out_instr", oins, hins);
        chk("fetch_fault", {31'h0, fault}, {31'h0, m_fault});
        if (s_rst) begin
            cyc++;
            model_reset();
            return;
        end
        if (rv) p = mp.pop_front();
        if (exp_req && g) begin
            p.a = m_fpc;
            p.due = cyc + $urandom_range(lat_max, lat_min);
            if (p.due <= last_due) p.due = last_due + 1;
            last_due = p.due;
            mp.push_back(p);
            m_fpc += 4;
            m_outst++;
        end
        if (s_redir) begin
            q.delete();
            m_fpc = s_ra;
            m_rpc = s_ra;
            if (rv) m_outst--;
            m_discard = m_outst;
            m_fault = s_ra[1:0] != 2'b00;
        end else begin
            if (q.size() > 0 && r) e = q.pop_front();
            if (rv) begin
                m_outst--;
                if (m_discard > 0) m_discard--;
                else begin
                    e.pc = m_rpc; e.ins = rdata;
                    q.push_back(e);
                    m_rpc += 4;
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        rst = 1'b1; redir = 1'b0; raddr = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; rdy = 1'b0;
        p_gnt = 100; p_ready = 100; lat_min = 1; lat_max = 1;
        repeat (2) @(posedge clk);
        model_reset();
        step(1'b1, 1'b0, 32'h0);
        run(20);
        p_ready = 0;
        run(12);
        p_ready = 100;
        run(10);
        lat_min = 3; lat_max = 3;
        run(3);
        step(1'b0, 1'b1, 32'h100);
        run(12);
        lat_min = 2; lat_max = 2; p_ready = 0;
        step(1'b0, 1'b1, 32'h200);
        for (int k = 0; k < 60 && !(q.size() == DEPTH - 1 && mp.size() > 0 && mp[0].due <= cyc); k++)
            step(1'b0, 1'b0, 32'h0);
        p_ready = 100;
        step(1'b0, 1'b1, 32'h300);
        run(10);
        step(1'b0, 1'b1, 32'h102);
        run(10);
        step(1'b0, 1'b1, 32'h200);
        run(10);
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        run(8);
        p_ready = 0;
        for (int k = 0; k < 40 && q.size() < 2; k++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        p_ready = 100;
        run(10);
        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic [31:0] ra;
            if (i % 200 == 0) begin
                p_gnt = $urandom_range(100, 20);
                p_ready = $urandom_range(100, 0);
                lat_min = $urandom_range(3, 1);
                lat_max = lat_min + $urandom_range(3, 0);
            end
            r = $urandom_range(999);
            ra = $urandom;
            ra[1:0] = r < 8 ? 2'b10 : 2'b00;
            step(r > 995, r < 30, ra);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
